// File: rtl/ram_arbiter_if.sv
// Requester-side bus of ram_arbiter: per-port req/we/addr/wdata packed by port,
// one-hot gnt/rvalid pulses, shared rdata and busy.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                busy;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/ram_arbiter.sv
// Three-port RAM arbiter: IDLE/ISSUE/RESP FSM, one access outstanding, 1-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 1 > 0 > 2.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      bus,
    output logic              ram_write_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_write_adress,
    output logic [ADDR_W-1:0] ram_rd_adress,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        win;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        pick;
    logic              any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic       found;

    // Search starts one past the last granted port, wrapping mod 3.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % 3]) begin
                pick  = 2'((int'(ptr) + k) % 3);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = 2'd0;
        if (bus.req[1])      pick = 2'd1;
        else if (bus.req[0]) pick = 2'd0;
        else if (bus.req[2]) pick = 2'd2;
    end
`endif

    assign any_req = |bus.req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            win       <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr       <= 2'd2;
`endif
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        win       <= pick;
                        lat_we    <= bus.we[pick];
                        lat_addr  <= bus.addr[int'(pick)*ADDR_W +: ADDR_W];
                        lat_wdata <= bus.wdata[int'(pick)*DATA_W +: DATA_W];
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state <= lat_we ? IDLE : RESP;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr   <= win;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state/latch only, so reset zeroes them at once.
    always_comb begin
        bus.gnt          = '0;
        bus.rvalid       = '0;
        bus.rdata        = '0;
        ram_write_en     = 1'b0;
        ram_rd_en        = 1'b0;
        ram_write_adress = '0;
        ram_rd_adress    = '0;
        ram_data_in      = '0;
        if (state == ISSUE) begin
            bus.gnt = 3'b001 << win;
            if (lat_we) begin
                ram_write_en     = 1'b1;
                ram_write_adress = lat_addr;
                ram_data_in      = lat_wdata;
            end else begin
                ram_rd_en     = 1'b1;
                ram_rd_adress = lat_addr;
            end
        end else if (state == RESP) begin
            bus.rvalid = 3'b001 << win;
            bus.rdata  = ram_data_out;
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ram_write_en, ram_rd_en;
    logic [7:0] ram_write_adress, ram_rd_adress, ram_data_in;
    logic [7:0] ram_data_out;
    logic [7:0] mem [256];
    int         checks = 0;
    int         passed = 0;
    int         p2_gnt_cnt = 0;
    int         p2_ram_cnt = 0;
    logic [40:0] all_outs;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_write_en(ram_write_en), .ram_rd_en(ram_rd_en),
        .ram_write_adress(ram_write_adress), .ram_rd_adress(ram_rd_adress),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    assign all_outs = {bus.gnt, bus.rvalid, bus.busy, bus.rdata, ram_write_en, ram_rd_en,
                       ram_write_adress, ram_rd_adress, ram_data_in};

    // RAM model; preload is applied whenever reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h10]   <= 8'hA5;
            mem[8'hFF]   <= 8'h5A;
            ram_data_out <= 8'h00;
        end else begin
            if (ram_write_en) mem[ram_write_adress] <= ram_data_in;
            if (ram_rd_en)    ram_data_out <= mem[ram_rd_adress];
        end
    end

    always @(posedge clk) begin
        if (bus.gnt[2]) p2_gnt_cnt <= p2_gnt_cnt + 1;
        if ((ram_write_en && ram_write_adress == 8'h77) || (ram_rd_en && ram_rd_adress == 8'h77))
            p2_ram_cnt <= p2_ram_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.we[p]          = w;
        bus.addr[p*8 +: 8] = a;
        bus.wdata[p*8 +: 8] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.req = 3'b000; bus.we = 3'b000; bus.addr = '0; bus.wdata = '0;
        rst = 1'b0;
        step();
        step();
        checks++; if (all_outs !== 41'd0) $display("FAIL reset_outs got=%h exp=0", all_outs); else passed++;
        rst = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    endtask

    task automatic test_read();
        set_port(0, 1'b0, 8'h10, 8'h00);
        bus.req = 3'b001;
        step();
        checks++; if (bus.gnt !== 3'b001) $display("FAIL rd_gnt got=%b exp=001", bus.gnt); else passed++;
        checks++; if ({ram_rd_en, ram_rd_adress, ram_write_en, ram_write_adress} !== {1'b1, 8'h10, 1'b0, 8'h00})
            $display("FAIL rd_ram got=%b/%h/%b/%h exp=1/10/0/00", ram_rd_en, ram_rd_adress, ram_write_en, ram_write_adress);
        else passed++;
        bus.req = 3'b000;
        step();
        checks++; if ({bus.gnt, bus.rvalid, bus.rdata} !== {3'b000, 3'b001, 8'hA5})
            $display("FAIL rd_resp got=%b/%b/%h exp=000/001/a5", bus.gnt, bus.rvalid, bus.rdata);
        else passed++;
        step();
        checks++; if ({bus.busy, bus.rvalid} !== 4'b0000) $display("FAIL rd_idle got=%b/%b exp=0/000", bus.busy, bus.rvalid); else passed++;
    endtask

    task automatic test_write_then_read();
        set_port(1, 1'b1, 8'h20, 8'h3C);
        bus.req = 3'b010;
        step();
        checks++; if ({bus.gnt, ram_write_en, ram_write_adress, ram_data_in, ram_rd_en, ram_rd_adress} !== {3'b010, 1'b1, 8'h20, 8'h3C, 1'b0, 8'h00})
            $display("FAIL wr_issue got=%b/%b/%h/%h/%b/%h exp=010/1/20/3c/0/00", bus.gnt, ram_write_en, ram_write_adress, ram_data_in, ram_rd_en, ram_rd_adress);
        else passed++;
        set_port(0, 1'b0, 8'h20, 8'h00);
        bus.req = 3'b001;
        step();
        checks++; if ({bus.gnt, bus.busy} !== 4'b0000) $display("FAIL wr_gap got=%b/%b exp=000/0", bus.gnt, bus.busy); else passed++;
        step();
        checks++; if ({bus.gnt, ram_rd_en} !== 4'b0011) $display("FAIL wr_rd_gnt got=%b/%b exp=001/1", bus.gnt, ram_rd_en); else passed++;
        bus.req = 3'b000;
        step();
        checks++; if ({bus.rvalid, bus.rdata} !== {3'b001, 8'h3C}) $display("FAIL wr_rd_data got=%b/%h exp=001/3c", bus.rvalid, bus.rdata); else passed++;
        step();
    endtask

    task automatic test_all_req();
        logic [2:0] expg [4];
        logic [7:0] expd;
`ifdef ARB_ROUND_ROBIN_EN
        expg = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        expg = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
        bus.req = 3'b000;
        do_reset();
        set_port(0, 1'b0, 8'h10, 8'h00);
        set_port(1, 1'b0, 8'h20, 8'h00);
        set_port(2, 1'b0, 8'hFF, 8'h00);
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({bus.gnt, bus.rvalid} !== {expg[i], 3'b000})
                $display("FAIL all_gnt[%0d] got=%b/%b exp=%b/000", i, bus.gnt, bus.rvalid, expg[i]);
            else passed++;
            step();
            expd = (expg[i] == 3'b001) ? 8'hA5 : (expg[i] == 3'b010) ? 8'h3C : 8'h5A;
            checks++; if ({bus.gnt, bus.rvalid, bus.rdata} !== {3'b000, expg[i], expd})
                $display("FAIL all_resp[%0d] got=%b/%b/%h exp=000/%b/%h", i, bus.gnt, bus.rvalid, bus.rdata, expg[i], expd);
            else passed++;
        end
        bus.req = 3'b000;
        step();
        step();
        step();
    endtask

    task automatic test_drop_req();
        int g0, r0;
        g0 = p2_gnt_cnt;
        r0 = p2_ram_cnt;
        set_port(1, 1'b1, 8'h30, 8'h11);
        set_port(2, 1'b1, 8'h77, 8'h99);
        bus.req = 3'b010;
        step();
        checks++; if (bus.gnt !== 3'b010) $display("FAIL drop_p1_gnt got=%b exp=010", bus.gnt); else passed++;
        bus.req = 3'b100;
        step();
        bus.req = 3'b000;
        for (int i = 0; i < 4; i++) step();
        checks++; if (p2_gnt_cnt - g0 !== 0) $display("FAIL drop_p2_gnt got=%0d exp=0", p2_gnt_cnt - g0); else passed++;
        checks++; if (p2_ram_cnt - r0 !== 0) $display("FAIL drop_p2_ram got=%0d exp=0", p2_ram_cnt - r0); else passed++;
        checks++; if (mem[8'h30] !== 8'h11) $display("FAIL drop_p1_wr got=%h exp=11", mem[8'h30]); else passed++;
    endtask

    task automatic test_reset_resp();
        int bad;
        set_port(0, 1'b0, 8'h10, 8'h00);
        bus.req = 3'b001;
        step();
        bus.req = 3'b000;
        step();
        checks++; if (bus.rvalid !== 3'b001) $display("FAIL rr_pre got=%b exp=001", bus.rvalid); else passed++;
        #1 rst = 1'b0;
        #1;
        checks++; if (all_outs !== 41'd0) $display("FAIL rr_async got=%h exp=0", all_outs); else passed++;
        step();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.rvalid !== 3'b000 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rr_no_rvalid got=%0d exp=0", bad); else passed++;
        set_port(2, 1'b0, 8'hFF, 8'h00);
        bus.req = 3'b100;
        step();
        checks++; if ({bus.gnt, ram_rd_adress} !== {3'b100, 8'hFF}) $display("FAIL rr_next_gnt got=%b/%h exp=100/ff", bus.gnt, ram_rd_adress); else passed++;
        bus.req = 3'b000;
        step();
        checks++; if ({bus.rvalid, bus.rdata} !== {3'b100, 8'h5A}) $display("FAIL rr_next_data got=%b/%h exp=100/5a", bus.rvalid, bus.rdata); else passed++;
        step();
    endtask

    task automatic test_boundary();
        set_port(0, 1'b1, 8'h00, 8'hC3);
        bus.req = 3'b001;
        step();
        checks++; if ({bus.gnt, ram_write_en, ram_write_adress, ram_data_in} !== {3'b001, 1'b1, 8'h00, 8'hC3})
            $display("FAIL bnd_wr got=%b/%b/%h/%h exp=001/1/00/c3", bus.gnt, ram_write_en, ram_write_adress, ram_data_in);
        else passed++;
        set_port(0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        bus.req = 3'b000;
        step();
        checks++; if ({bus.rvalid, bus.rdata} !== {3'b001, 8'hC3}) $display("FAIL bnd_rd00 got=%b/%h exp=001/c3", bus.rvalid, bus.rdata); else passed++;
        set_port(0, 1'b0, 8'hFF, 8'h00);
        bus.req = 3'b001;
        step();
        checks++; if ({ram_rd_en, ram_rd_adress} !== {1'b1, 8'hFF}) $display("FAIL bnd_rdff_addr got=%b/%h exp=1/ff", ram_rd_en, ram_rd_adress); else passed++;
        bus.req = 3'b000;
        step();
        checks++; if (bus.rdata !== 8'h5A) $display("FAIL bnd_rdff_data got=%h exp=5a", bus.rdata); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_then_read();
        test_all_req();
        test_drop_req();
        test_reset_resp();
        test_boundary();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
